// File: rtl/column_stack.sv
// column_stack: six-cell bottom-up stacking column with a drop/land FSM.
// Optional macro FALL_ANIM_EN animates the falling token one row per FALL_TICKS cycles.
module column_stack #(
  parameter int FALL_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       drop,
  input  logic [1:0] player,
  output logic [1:0] q0,
  output logic [1:0] q1,
  output logic [1:0] q2,
  output logic [1:0] q3,
  output logic [1:0] q4,
  output logic [1:0] q5,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic       reject,
  output logic [2:0] land_row
);

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } state_t;

  localparam logic [2:0] ROWS = 3'd6;

  state_t     state_q, state_d;
  logic [1:0] cells_q [6];
  logic [1:0] cells_d [6];
  logic [1:0] q_q [6];
  logic [1:0] q_d [6];
  logic [2:0] n_q, n_d;
  logic [2:0] land_row_q, land_row_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       drop_ok;
  logic       land;
  logic [1:0] land_tok;

`ifdef FALL_ANIM_EN
  localparam logic [7:0] TICK_LAST = 8'(FALL_TICKS - 1);

  logic [1:0] tok_q, tok_d;
  logic [2:0] target_q, target_d;
  logic [2:0] cursor_q, cursor_d;
  logic [7:0] tick_q, tick_d;
`endif

  generate
    if (FALL_TICKS < 1 || FALL_TICKS > 255) begin : g_bad_ticks
      $error("column_stack: FALL_TICKS must be in 1..255");
    end
  endgenerate

  assign full    = (n_q == ROWS);
  assign drop_ok = (player == 2'b01 || player == 2'b10) && !full;

  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    n_d        = n_q;
    land_row_d = land_row_q;
    done_d     = 1'b0;
    reject_d   = 1'b0;
    land       = 1'b0;
    land_tok   = 2'b00;
`ifdef FALL_ANIM_EN
    tok_d      = tok_q;
    target_d   = target_q;
    cursor_d   = cursor_q;
    tick_d     = tick_q;
`endif
    // clear behaves like reset and swallows any same-cycle drop
    if (clear) begin
      state_d    = IDLE;
      n_d        = 3'd0;
      land_row_d = 3'd0;
      for (int i = 0; i < 6; i++) begin
        cells_d[i] = 2'b00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (drop) begin
            if (!drop_ok) begin
              reject_d = 1'b1;
            end else begin
`ifdef FALL_ANIM_EN
              tok_d    = player;
              target_d = n_q;
              cursor_d = 3'd5;
              tick_d   = 8'd0;
              state_d  = FALL;
`else
              // without animation the fall collapses into the accepting edge
              land     = 1'b1;
              land_tok = player;
`endif
            end
          end
        end
        FALL: begin
`ifdef FALL_ANIM_EN
          if (tick_q == TICK_LAST) begin
            if (cursor_q == target_q) begin
              land     = 1'b1;
              land_tok = tok_q;
              state_d  = IDLE;
            end else begin
              cursor_d = cursor_q - 3'd1;
              tick_d   = 8'd0;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase

      if (land) begin
        for (int i = 0; i < 6; i++) begin
          if (3'(i) == n_q) begin
            cells_d[i] = land_tok;
          end
        end
        n_d        = n_q + 3'd1;
        land_row_d = n_q;
        done_d     = 1'b1;
      end
    end
  end

  // Registered display: stored cells, with the falling token overlaid above its target
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      q_d[i] = cells_d[i];
`ifdef FALL_ANIM_EN
      if (state_d == FALL && cursor_d == 3'(i) && cursor_d > target_d) begin
        q_d[i] = tok_d;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= 3'd0;
      land_row_q <= 3'd0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        cells_q[i] <= 2'b00;
        q_q[i]     <= 2'b00;
      end
`ifdef FALL_ANIM_EN
      tok_q    <= 2'b00;
      target_q <= 3'd0;
      cursor_q <= 3'd0;
      tick_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      land_row_q <= land_row_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      cells_q    <= cells_d;
      q_q        <= q_d;
`ifdef FALL_ANIM_EN
      tok_q    <= tok_d;
      target_q <= target_d;
      cursor_q <= cursor_d;
      tick_q   <= tick_d;
`endif
    end
  end

  assign q0       = q_q[0];
  assign q1       = q_q[1];
  assign q2       = q_q[2];
  assign q3       = q_q[3];
  assign q4       = q_q[4];
  assign q5       = q_q[5];
  assign busy     = (state_q == FALL);
  assign done     = done_q;
  assign reject   = reject_q;
  assign land_row = land_row_q;

endmodule

// File: tb/tb_column_stack.sv
// Self-checking bench for column_stack: vector table, directed fall sequences,
// and randomized traffic against a transaction-level column model.
module tb_column_stack;

  localparam int FT = 2;

  logic       clk = 1'b0;
  logic       rst, clear, drop;
  logic [1:0] player;
  logic [1:0] q0, q1, q2, q3, q4, q5;
  logic       busy, full, done, reject;
  logic [2:0] land_row;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  column_stack #(.FALL_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .drop(drop), .player(player),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .busy(busy), .full(full), .done(done), .reject(reject), .land_row(land_row)
  );

  // Reference model: column contents plus an in-flight drop timed in whole cycles
  logic [1:0] m_cells [6];
  int         m_n, m_target, m_elapsed, m_total, m_land_row;
  bit         m_fall, m_done, m_reject;
  logic [1:0] m_tok;

  function automatic void model_land();
    m_cells[m_n] = m_tok;
    m_land_row   = m_n;
    m_n          = m_n + 1;
    m_done       = 1'b1;
  endfunction

  function automatic void model_step(bit r, bit c, bit d, logic [1:0] p);
    m_done   = 1'b0;
    m_reject = 1'b0;
    if (r || c) begin
      for (int i = 0; i < 6; i++) m_cells[i] = 2'b00;
      m_n = 0; m_fall = 1'b0; m_land_row = 0;
    end else if (m_fall) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == m_total) begin
        m_fall = 1'b0;
        model_land();
      end
    end else if (d) begin
      if (m_n == 6 || p == 2'b00 || p == 2'b11) begin
        m_reject = 1'b1;
      end else begin
        m_tok = p;
`ifdef FALL_ANIM_EN
        m_fall    = 1'b1;
        m_target  = m_n;
        m_elapsed = 0;
        m_total   = (6 - m_n) * FT;
`else
        model_land();
`endif
      end
    end
  endfunction

  function automatic logic [18:0] model_vec();
    logic [11:0] qv;
    int row;
    qv = '0;
    for (int i = 0; i < 6; i++) qv[2*i +: 2] = m_cells[i];
    if (m_fall) begin
      row = 5 - m_elapsed / FT;
      if (row > m_target) qv[2*row +: 2] = m_tok;
    end
    return {qv, m_fall, (m_n == 6), m_done, m_reject, 3'(m_land_row)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {q5, q4, q3, q2, q1, q0, busy, full, done, reject, land_row};
  endfunction

  task automatic apply(input bit r, input bit c, input bit d, input logic [1:0] p);
    rst = r; clear = c; drop = d; player = p;
    model_step(r, c, d, p);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [18:0] exp);
    logic [18:0] got;
    got = dut_vec();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b full=%b done=%b reject=%b land_row=%0d, expected q=%h busy=%b full=%b done=%b reject=%b land_row=%0d",
               tag, got[18:7], got[6], got[5], got[4], got[3], got[2:0],
               exp[18:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end else begin
      $display("ok   %s: q=%h busy=%b full=%b done=%b reject=%b land_row=%0d",
               tag, got[18:7], got[6], got[5], got[4], got[3], got[2:0]);
    end
  endtask

  function automatic logic [18:0] mk_exp(logic [11:0] qv, bit b, bit f, bit dn, bit rj, logic [2:0] lr);
    return {qv, b, f, dn, rj, lr};
  endfunction

`ifndef FALL_ANIM_EN
  typedef struct {
    bit          r, c, d;
    logic [1:0]  p;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(bit r, bit c, bit d, logic [1:0] p, logic [18:0] exp);
    vec_t v;
    v.r = r; v.c = c; v.d = d; v.p = p; v.exp = exp;
    return v;
  endfunction
`endif

  initial begin
    logic [11:0] qv;
    int row;
    rst = 1'b1; clear = 1'b0; drop = 1'b0; player = 2'b00;
    for (int i = 0; i < 6; i++) m_cells[i] = 2'b00;
    m_n = 0; m_fall = 1'b0; m_land_row = 0; m_done = 1'b0; m_reject = 1'b0;
    m_target = 0; m_elapsed = 0; m_total = 0; m_tok = 2'b00;

`ifndef FALL_ANIM_EN
    //            r  c  d  p      q       busy full done rej lr
    tbl[0]  = mk(1, 0, 0, 2'b00, mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    tbl[1]  = mk(0, 0, 1, 2'b01, mk_exp(12'h001, 0, 0, 1, 0, 3'd0));
    tbl[2]  = mk(0, 0, 0, 2'b00, mk_exp(12'h001, 0, 0, 0, 0, 3'd0));
    tbl[3]  = mk(0, 0, 1, 2'b11, mk_exp(12'h001, 0, 0, 0, 1, 3'd0));
    tbl[4]  = mk(0, 0, 1, 2'b00, mk_exp(12'h001, 0, 0, 0, 1, 3'd0));
    tbl[5]  = mk(0, 0, 1, 2'b10, mk_exp(12'h009, 0, 0, 1, 0, 3'd1));
    tbl[6]  = mk(0, 0, 1, 2'b01, mk_exp(12'h019, 0, 0, 1, 0, 3'd2));
    tbl[7]  = mk(0, 1, 1, 2'b10, mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    tbl[8]  = mk(0, 0, 1, 2'b01, mk_exp(12'h001, 0, 0, 1, 0, 3'd0));
    tbl[9]  = mk(0, 0, 1, 2'b10, mk_exp(12'h009, 0, 0, 1, 0, 3'd1));
    tbl[10] = mk(0, 0, 1, 2'b01, mk_exp(12'h019, 0, 0, 1, 0, 3'd2));
    tbl[11] = mk(0, 0, 1, 2'b10, mk_exp(12'h099, 0, 0, 1, 0, 3'd3));
    tbl[12] = mk(0, 0, 1, 2'b01, mk_exp(12'h199, 0, 0, 1, 0, 3'd4));
    tbl[13] = mk(0, 0, 1, 2'b10, mk_exp(12'h999, 0, 1, 1, 0, 3'd5));
    tbl[14] = mk(0, 0, 1, 2'b10, mk_exp(12'h999, 0, 1, 0, 1, 3'd5));
    tbl[15] = mk(0, 0, 0, 2'b00, mk_exp(12'h999, 0, 1, 0, 0, 3'd5));
    tbl[16] = mk(0, 1, 0, 2'b00, mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    tbl[17] = mk(1, 0, 1, 2'b01, mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].p);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end
`else
    // Animated fall from an empty column, two cycles per row
    apply(1, 0, 0, 2'b00);
    check("reset", mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    apply(0, 0, 1, 2'b10);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) apply(0, 0, 0, 2'b00);
      qv = '0;
      if (c <= 12) begin
        row = 5 - (c - 1) / 2;
        if (row > 0) qv[2*row +: 2] = 2'b10;
        check($sformatf("fall cycle %0d", c), mk_exp(qv, 1, 0, 0, 0, 3'd0));
      end else begin
        check("fall landed", mk_exp(12'h002, 0, 0, 1, 0, 3'd0));
      end
    end
    // Abort mid-fall with clear; a drop while busy must not reject
    apply(0, 0, 1, 2'b01);
    check("second accept", mk_exp(12'h402, 1, 0, 0, 0, 3'd0));
    apply(0, 0, 0, 2'b00);
    apply(0, 0, 1, 2'b10);
    check("drop while busy", mk_exp(12'h102, 1, 0, 0, 0, 3'd0));
    apply(0, 1, 0, 2'b00);
    check("clear mid-fall", mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    for (int c = 0; c < 12; c++) begin
      apply(0, 0, 0, 2'b00);
      check($sformatf("after abort %0d", c), mk_exp(12'h000, 0, 0, 0, 0, 3'd0));
    end
`endif

    // Randomized traffic against the model
    apply(1, 0, 0, 2'b00);
    check("random reset", model_vec());
    for (int n = 0; n < 1500; n++) begin
      bit r, c, d;
      logic [1:0] p;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      d = ($urandom_range(0, 2) == 0);
      p = 2'($urandom_range(0, 3));
      apply(r, c, d, p);
      if (r || c || d || done || reject) begin
        check($sformatf("rand %0d r=%b c=%b d=%b p=%b", n, r, c, d, p), model_vec());
      end else begin
        vectors++;
        if (dut_vec() !== model_vec()) begin
          miscompares++;
          $display("FAIL rand %0d: got %h expected %h", n, dut_vec(), model_vec());
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
